// File: rtl/de2_switch_debouncer_pkg.sv
// ============================================================================
// Module : de2_io_pkg
// Brief  : Shared widths and defaults for the DE2 switch debouncer slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package de2_io_pkg;

   localparam int SW_WIDTH         = 18;
   localparam int DEB_CNT_W        = 4;
   localparam int GLITCH_CNT_W     = 16;
   localparam int DEF_TICK_DIV     = 50000;
   localparam int DEF_STABLE_TICKS = 10;

   typedef logic [DEB_CNT_W-1:0]    deb_cnt_t;
   typedef logic [GLITCH_CNT_W-1:0] glitch_cnt_t;

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   function automatic glitch_cnt_t sat_inc(input glitch_cnt_t v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/de2_switch_debouncer_if.sv
// ============================================================================
// Module : de2_switch_debouncer_if
// Brief  : Switch-side bundle between raw switches / PIO and the debouncer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface de2_switch_debouncer_if
   import de2_io_pkg::*;
#(
   parameter int WIDTH = SW_WIDTH
) ();

   logic [WIDTH-1:0] sw_in;
   logic             glitch_clr;
   logic [WIDTH-1:0] sw_out;
   logic [WIDTH-1:0] sw_changed;
   logic             any_change;
   glitch_cnt_t      glitch_count;

   modport master (
      output sw_in,
      output glitch_clr,
      input  sw_out,
      input  sw_changed,
      input  any_change,
      input  glitch_count
   );

   modport slave (
      input  sw_in,
      input  glitch_clr,
      output sw_out,
      output sw_changed,
      output any_change,
      output glitch_count
   );

endinterface

`default_nettype wire

// File: rtl/de2_switch_debouncer_debounce_bit.sv
// ============================================================================
// Module : debounce_bit
// Brief  : One-bit stability counter with registered level and change pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module debounce_bit
   import de2_io_pkg::*;
#(
   parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic i_tick,
   input  wire logic i_sync,
   output logic      o_sw_out,
   output logic      o_sw_changed,
   output logic      o_glitch
);

   localparam deb_cnt_t c_last = deb_cnt_t'(STABLE_TICKS - 1);

   deb_cnt_t r_cnt;
   logic     r_sw_out;
   logic     r_changed;
   logic     w_match;

   assign w_match = (i_sync == r_sw_out);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt     <= '0;
         r_sw_out  <= 1'b0;
         r_changed <= 1'b0;
      end else begin
         r_changed <= 1'b0;
         if (w_match) begin
            r_cnt <= '0;
         end else if (i_tick) begin
            if (r_cnt == c_last) begin
               r_sw_out  <= i_sync;
               r_cnt     <= '0;
               r_changed <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   // A partial count abandoned because the input fell back is a rejected glitch.
   assign o_glitch     = (r_cnt != '0) && w_match;
   assign o_sw_out     = r_sw_out;
   assign o_sw_changed = r_changed;

endmodule

`default_nettype wire

// File: rtl/de2_switch_debouncer.sv
// ============================================================================
// Module : de2_switch_debouncer
// Brief  : Synchronise + debounce DE2 slide switches ahead of the switch PIO.
//          Glitch counter built only with DE2_DEBOUNCE_GLITCH_COUNT_EN defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module de2_switch_debouncer
   import de2_io_pkg::*;
#(
   parameter int WIDTH        = SW_WIDTH,
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
   input  wire logic                clk,
   input  wire logic                reset,
   de2_switch_debouncer_if.slave    bus
);

   localparam int                  PRESC_W      = $clog2(TICK_DIV);
   localparam logic [PRESC_W-1:0]  c_presc_last = PRESC_W'(TICK_DIV - 1);

   logic [WIDTH-1:0]   r_sync1;
   logic [WIDTH-1:0]   r_sync2;
   logic [PRESC_W-1:0] r_presc;
   logic               w_tick;
   logic [WIDTH-1:0]   w_sw_out;
   logic [WIDTH-1:0]   w_sw_changed;
   logic [WIDTH-1:0]   w_glitch;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= bus.sw_in;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc <= '0;
      end else if (r_presc == c_presc_last) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   assign w_tick = (r_presc == c_presc_last);

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS)
         ) u_bit (
            .clk          (clk),
            .reset        (reset),
            .i_tick       (w_tick),
            .i_sync       (r_sync2[i]),
            .o_sw_out     (w_sw_out[i]),
            .o_sw_changed (w_sw_changed[i]),
            .o_glitch     (w_glitch[i])
         );
      end
   endgenerate

   assign bus.sw_out     = w_sw_out;
   assign bus.sw_changed = w_sw_changed;
   assign bus.any_change = |w_sw_changed;

`ifdef DE2_DEBOUNCE_GLITCH_COUNT_EN
   glitch_cnt_t r_glitch_count;

   // One increment per cycle however many bits reject; clear wins over count.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_glitch_count <= '0;
      end else if (bus.glitch_clr) begin
         r_glitch_count <= '0;
      end else if (|w_glitch) begin
         r_glitch_count <= sat_inc(r_glitch_count);
      end
   end

   assign bus.glitch_count = r_glitch_count;
`else
   logic w_unused_glitch;

   assign w_unused_glitch  = ^{w_glitch, bus.glitch_clr};
   assign bus.glitch_count = '0;
`endif

endmodule

`default_nettype wire

// File: doc/de2_switch_debouncer.md
Name: de2_switch_debouncer

Overview:
- Conditioning stage directly upstream of the 18-bit toggle-switch PIO; its sw_out drives that PIO's in_port.
- Synchronises raw DE2 slide-switch inputs into clk, rejects contact bounce with a shared sample-tick prescaler and per-bit stability counters, and emits per-bit change pulses.
- Guarantees the PIO edge-capture logic sees exactly one clean transition per physical switch flip.

Parameters:
- WIDTH, 18: number of switch bits.
- TICK_DIV, 50000: clk cycles per sample tick (1 ms at 50 MHz); must be ≥2.
- STABLE_TICKS, 10: consecutive mismatching ticks required to accept a new level; must be ≥1 and ≤15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sw_in  in  WIDTH  raw asynchronous switch levels.
- glitch_clr  in  1  clears glitch_count (clk domain).
- sw_out  out  WIDTH  debounced switch levels (to PIO in_port).
- sw_changed  out  WIDTH  one-cycle pulse per bit when sw_out[i] changes.
- any_change  out  1  OR of sw_changed (combinational from registers).
- glitch_count  out  16  rejected-glitch counter (see Optional Feature).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (sampled on clk edge): sync stages, sw_out, sw_changed, prescaler, all bit counters and glitch_count go to 0. A reset mid-count discards partial counts; no pulse is emitted.
- Synchroniser: two flops per bit, sync1<=sw_in and sync2<=sync1. Only sync2 is used downstream.
- Prescaler:
  - presc counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 exactly in the cycle presc==TICK_DIV-1, giving one tick per TICK_DIV cycles.
- Per bit i, with a 4-bit cnt:
  - If sync2[i]==sw_out[i]: cnt<=0, no change.
  - Else if tick and cnt==STABLE_TICKS-1: sw_out[i]<=sync2[i], cnt<=0, sw_changed[i]<=1.
  - Else if tick: cnt<=cnt+1.
  - Else: hold.
  - sw_changed[i] is 0 in every cycle not covered above; it is registered alongside sw_out, so the pulse coincides with the first cycle sw_out shows the new value.
- Latency:
  - A clean step on sw_in reaches sw_out after ≥2+(STABLE_TICKS-1)*TICK_DIV+1 and ≤2+STABLE_TICKS*TICK_DIV cycles.
  - With TICK_DIV=4 and STABLE_TICKS=3 this is 11..14 cycles.
- Glitch definition: a bit whose cnt≠0 sees sync2[i]==sw_out[i]. It is a rejected glitch and cnt clears.
- Bits are fully independent. Simultaneous changes on several bits each pulse in the same cycle. A bit flipping back and forth faster than the stability window never changes sw_out.
- Width rules: cnt is 4 bits, which bounds STABLE_TICKS to 15. The prescaler width is $clog2(TICK_DIV).

Optional Feature:
- Macro: DE2_DEBOUNCE_GLITCH_COUNT_EN.
- When defined:
  - glitch_count increments by 1 in any cycle where ≥1 bit rejects a glitch, regardless of how many bits do.
  - It saturates at 16'hFFFF.
  - glitch_clr forces 0 and has priority over an increment in the same cycle.
- When undefined: glitch_count is tied to 0, glitch_clr is ignored, and no counter logic is synthesised. The port list is identical in both cases.

Decomposition:
- Shared package de2_io_pkg: SW_WIDTH=18, DEB_CNT_W=4, GLITCH_CNT_W=16, default TICK_DIV/STABLE_TICKS constants.
- Sub-module debounce_bit holds one bit: cnt, sw_out bit, change pulse, glitch flag.
  - Inputs: clk, reset, tick, sync bit.
  - The top module holds the synchroniser, prescaler, a generate loop of WIDTH debounce_bit instances, the any_change OR and the glitch counter.

Test Plan (TICK_DIV=4, STABLE_TICKS=3, macro defined):
- Reset then sw_in=0 for 50 cycles -> sw_out=0, sw_changed never asserted, glitch_count=0.
- sw_in[5] 0->1 held -> sw_out[5]=1 between 11 and 14 cycles later; sw_changed[5] and any_change each high exactly 1 cycle; other bits unchanged.
- sw_in[0] high for 6 cycles then low -> sw_out[0] stays 0, no pulse, glitch_count=1.
- sw_in=18'h3FFFF step -> all bits rise in the same cycle, sw_changed=18'h3FFFF for 1 cycle; subsequent 18'h0 step -> all fall together.
- Assert reset for 1 cycle while bit 3 has cnt=2 -> sw_out[3] stays 0; after release the full 11..14 cycle window restarts.
- Force 65536 rejecting cycles -> glitch_count saturates at 16'hFFFF. glitch_clr in the same cycle as a glitch -> glitch_count=0.
